// File: rtl/iexecute_if.sv
// ID/EX input bundle and EX/MEM output bundle of the execute stage.
// master drives the ID/EX side; slave is the execute stage itself.
interface iexecute_if;
    logic        id_valid;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] npc;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] s_extend;
    logic [4:0]  instr_2016;
    logic [4:0]  instr_1511;

    logic        ex_busy;
    logic        ex_valid;
    logic [1:0]  ex_wb_ctl;
    logic [2:0]  ex_m_ctl;
    logic [31:0] ex_add_result;
    logic        ex_zero;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rdata2;
    logic [4:0]  ex_rd;

    modport master (
        output id_valid, wb_ctl, m_ctl, regdst, alusrc, aluop,
               npc, rdata1, rdata2, s_extend, instr_2016, instr_1511,
        input  ex_busy, ex_valid, ex_wb_ctl, ex_m_ctl, ex_add_result,
               ex_zero, ex_alu_result, ex_rdata2, ex_rd
    );

    modport slave (
        input  id_valid, wb_ctl, m_ctl, regdst, alusrc, aluop,
               npc, rdata1, rdata2, s_extend, instr_2016, instr_1511,
        output ex_busy, ex_valid, ex_wb_ctl, ex_m_ctl, ex_add_result,
               ex_zero, ex_alu_result, ex_rdata2, ex_rd
    );
endinterface

// File: rtl/iexecute.sv
// Execute stage: ALU, branch-target adder and EX/MEM register.
// Define IEXECUTE_MULT_EN to build in the 32-cycle shift-add multiplier (funct 0x18).
module iexecute #(
    parameter int SLT_SIGNED = 1
) (
    input  logic      clk,
    input  logic      rst,
    iexecute_if.slave bus
);

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    function automatic logic [31:0] alu_f(
        input logic [1:0]  op,
        input logic [5:0]  fn,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic signed [31:0] a_s;
        logic signed [31:0] b_s;
        logic               lt;
        a_s = a;
        b_s = b;
        lt  = (SLT_SIGNED != 0) ? (a_s < b_s) : (a < b);
        case (op)
            2'b01: alu_f = a - b;
            2'b10: begin
                case (fn)
                    F_ADD:   alu_f = a + b;
                    F_SUB:   alu_f = a - b;
                    F_AND:   alu_f = a & b;
                    F_OR:    alu_f = a | b;
                    F_SLT:   alu_f = {31'd0, lt};
                    default: alu_f = 32'd0;
                endcase
            end
            default: alu_f = a + b;
        endcase
    endfunction

    logic [5:0]  funct;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] add_res;
    logic [4:0]  rd_sel;
    logic        single;
    logic        busy;

    assign funct   = bus.s_extend[5:0];
    assign op_b    = bus.alusrc ? bus.s_extend : bus.rdata2;
    assign rd_sel  = bus.regdst ? bus.instr_1511 : bus.instr_2016;
    assign add_res = bus.npc + (bus.s_extend << 2);
    assign alu_res = alu_f(bus.aluop, funct, bus.rdata1, op_b);

    logic        valid_q, valid_d;
    logic [1:0]  wb_q, wb_d;
    logic [2:0]  m_q, m_d;
    logic [31:0] add_q, add_d;
    logic        zero_q, zero_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rdata2_q, rdata2_d;
    logic [4:0]  rd_q, rd_d;

`ifdef IEXECUTE_MULT_EN
    localparam logic [5:0] F_MUL = 6'h18;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] acc_q;
    logic [31:0] acc_step;
    logic [1:0]  mwb_q;
    logic [2:0]  mm_q;
    logic [31:0] madd_q;
    logic [31:0] mrdata2_q;
    logic [4:0]  mrd_q;
    logic        is_mult;
    logic        start;
    logic        mul_last;

    // Only IDLE accepts: in DONE the upstream is still presenting the finished mult.
    assign is_mult  = (bus.aluop == 2'b10) && (funct == F_MUL);
    assign start    = (state_q == S_IDLE) && bus.id_valid && is_mult;
    assign single   = (state_q == S_IDLE) && bus.id_valid && !is_mult;
    assign busy     = !rst && ((state_q == S_MUL) || start);
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    assign mul_last = (state_q == S_MUL) && (cnt_q == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
            acc_q     <= 32'd0;
            mwb_q     <= 2'd0;
            mm_q      <= 3'd0;
            madd_q    <= 32'd0;
            mrdata2_q <= 32'd0;
            mrd_q     <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_MUL;
                        cnt_q     <= 5'd0;
                        mcand_q   <= bus.rdata1;
                        mplier_q  <= op_b;
                        acc_q     <= 32'd0;
                        mwb_q     <= bus.wb_ctl;
                        mm_q      <= bus.m_ctl;
                        madd_q    <= add_res;
                        mrdata2_q <= bus.rdata2;
                        mrd_q     <= rd_sel;
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (mul_last) begin
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    assign single = bus.id_valid;
    assign busy   = 1'b0;
`endif

    // Non-accepting cycles are bubbles: control cleared, data held.
    always_comb begin
        valid_d  = 1'b0;
        wb_d     = 2'd0;
        m_d      = 3'd0;
        add_d    = add_q;
        zero_d   = zero_q;
        alu_d    = alu_q;
        rdata2_d = rdata2_q;
        rd_d     = rd_q;
        if (single) begin
            valid_d  = 1'b1;
            wb_d     = bus.wb_ctl;
            m_d      = bus.m_ctl;
            add_d    = add_res;
            zero_d   = (alu_res == 32'd0);
            alu_d    = alu_res;
            rdata2_d = bus.rdata2;
            rd_d     = rd_sel;
        end
`ifdef IEXECUTE_MULT_EN
        if (mul_last) begin
            valid_d  = 1'b1;
            wb_d     = mwb_q;
            m_d      = mm_q;
            add_d    = madd_q;
            zero_d   = (acc_step == 32'd0);
            alu_d    = acc_step;
            rdata2_d = mrdata2_q;
            rd_d     = mrd_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            wb_q     <= 2'd0;
            m_q      <= 3'd0;
            add_q    <= 32'd0;
            zero_q   <= 1'b0;
            alu_q    <= 32'd0;
            rdata2_q <= 32'd0;
            rd_q     <= 5'd0;
        end else begin
            valid_q  <= valid_d;
            wb_q     <= wb_d;
            m_q      <= m_d;
            add_q    <= add_d;
            zero_q   <= zero_d;
            alu_q    <= alu_d;
            rdata2_q <= rdata2_d;
            rd_q     <= rd_d;
        end
    end

    assign bus.ex_busy       = busy;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_wb_ctl     = wb_q;
    assign bus.ex_m_ctl      = m_q;
    assign bus.ex_add_result = add_q;
    assign bus.ex_zero       = zero_q;
    assign bus.ex_alu_result = alu_q;
    assign bus.ex_rdata2     = rdata2_q;
    assign bus.ex_rd         = rd_q;

endmodule

// File: tb/tb_iexecute.sv
// Directed bench for iexecute: signed-slt instance drives all checks, an unsigned-slt twin
// shares its inputs. Multiplier scenarios depend on IEXECUTE_MULT_EN.
module tb_iexecute;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    iexecute_if ifs ();
    iexecute_if ifu ();

    iexecute #(.SLT_SIGNED(1)) u_dut   (.clk(clk), .rst(rst), .bus(ifs.slave));
    iexecute #(.SLT_SIGNED(0)) u_dut_u (.clk(clk), .rst(rst), .bus(ifu.slave));

    assign ifu.id_valid   = ifs.id_valid;
    assign ifu.wb_ctl     = ifs.wb_ctl;
    assign ifu.m_ctl      = ifs.m_ctl;
    assign ifu.regdst     = ifs.regdst;
    assign ifu.alusrc     = ifs.alusrc;
    assign ifu.aluop      = ifs.aluop;
    assign ifu.npc        = ifs.npc;
    assign ifu.rdata1     = ifs.rdata1;
    assign ifu.rdata2     = ifs.rdata2;
    assign ifu.s_extend   = ifs.s_extend;
    assign ifu.instr_2016 = ifs.instr_2016;
    assign ifu.instr_1511 = ifs.instr_1511;

    task automatic set_op(input logic [1:0] op, input logic src, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm);
        ifs.id_valid = 1'b1;
        ifs.aluop    = op;
        ifs.alusrc   = src;
        ifs.rdata1   = a;
        ifs.rdata2   = b;
        ifs.s_extend = imm;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ifs.id_valid = 1'b0; ifs.wb_ctl = 2'd0; ifs.m_ctl = 3'd0; ifs.regdst = 1'b0;
        ifs.alusrc = 1'b0; ifs.aluop = 2'd0; ifs.npc = 32'd0; ifs.rdata1 = 32'd0;
        ifs.rdata2 = 32'd0; ifs.s_extend = 32'd0; ifs.instr_2016 = 5'd0; ifs.instr_1511 = 5'd0;
        repeat (2) tick();
        tests++; if (ifs.ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", ifs.ex_valid); end
        tests++; if (ifs.ex_alu_result !== 32'd0) begin fails++; $display("FAIL reset_alu got %h want 0", ifs.ex_alu_result); end
        tests++; if (ifs.ex_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", ifs.ex_busy); end
        tests++; if ({ifs.ex_wb_ctl, ifs.ex_m_ctl, ifs.ex_rd, ifs.ex_add_result} !== 42'd0) begin
            fails++; $display("FAIL reset_misc got %h want 0", {ifs.ex_wb_ctl, ifs.ex_m_ctl, ifs.ex_rd, ifs.ex_add_result});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add;
        ifs.wb_ctl = 2'b11; ifs.m_ctl = 3'b010; ifs.npc = 32'h1000;
        ifs.regdst = 1'b1; ifs.instr_1511 = 5'd3; ifs.instr_2016 = 5'd6;
        set_op(2'b10, 1'b0, 32'd5, 32'd7, 32'h20);
        tick();
        tests++; if (ifs.ex_alu_result !== 32'd12) begin fails++; $display("FAIL add_result got %h want 0000000c", ifs.ex_alu_result); end
        tests++; if (ifs.ex_zero !== 1'b0) begin fails++; $display("FAIL add_zero got %b want 0", ifs.ex_zero); end
        tests++; if (ifs.ex_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %b want 1", ifs.ex_valid); end
        tests++; if (ifs.ex_add_result !== 32'h1080) begin fails++; $display("FAIL add_target got %h want 00001080", ifs.ex_add_result); end
        tests++; if ({ifs.ex_wb_ctl, ifs.ex_m_ctl} !== 5'b11010) begin fails++; $display("FAIL add_ctl got %b want 11010", {ifs.ex_wb_ctl, ifs.ex_m_ctl}); end
        tests++; if ({ifs.ex_rd, ifs.ex_rdata2} !== {5'd3, 32'd7}) begin fails++; $display("FAIL add_rd_data got %h want %h", {ifs.ex_rd, ifs.ex_rdata2}, {5'd3, 32'd7}); end
        @(negedge clk);
        ifs.id_valid = 1'b0;
        tick();
        tests++; if (ifs.ex_valid !== 1'b0) begin fails++; $display("FAIL add_one_cycle got %b want 0", ifs.ex_valid); end
        tests++; if ({ifs.ex_wb_ctl, ifs.ex_m_ctl} !== 5'd0) begin fails++; $display("FAIL bubble_ctl got %b want 0", {ifs.ex_wb_ctl, ifs.ex_m_ctl}); end
        tests++; if ({ifs.ex_alu_result, ifs.ex_add_result} !== {32'd12, 32'h1080}) begin
            fails++; $display("FAIL bubble_hold got %h want %h", {ifs.ex_alu_result, ifs.ex_add_result}, {32'd12, 32'h1080});
        end
    endtask

    task automatic test_sub_branch;
        @(negedge clk);
        ifs.npc = 32'h100; ifs.m_ctl = 3'b100;
        set_op(2'b01, 1'b0, 32'h1234, 32'h1234, 32'hFFFF_FFFF);
        tick();
        tests++; if (ifs.ex_zero !== 1'b1) begin fails++; $display("FAIL sub_zero got %b want 1", ifs.ex_zero); end
        tests++; if (ifs.ex_alu_result !== 32'd0) begin fails++; $display("FAIL sub_result got %h want 0", ifs.ex_alu_result); end
        tests++; if (ifs.ex_add_result !== 32'hFC) begin fails++; $display("FAIL branch_target got %h want 000000fc", ifs.ex_add_result); end
        tests++; if (ifs.ex_m_ctl !== 3'b100) begin fails++; $display("FAIL branch_mctl got %b want 100", ifs.ex_m_ctl); end
    endtask

    task automatic test_alu_ops;
        logic [1:0]  op_t [6];
        logic        src_t [6];
        logic [31:0] a_t [6];
        logic [31:0] b_t [6];
        logic [31:0] i_t [6];
        logic [31:0] e_t [6];
        op_t  = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b11, 2'b01};
        src_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        a_t   = '{32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'd100, 32'hFFFF_FFFF, 32'd0};
        b_t   = '{32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'd0, 32'd1, 32'd1};
        i_t   = '{32'h24, 32'h25, 32'h3F, 32'hFFFF_FFFE, 32'd0, 32'd0};
        e_t   = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'd0, 32'd98, 32'd0, 32'hFFFF_FFFF};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_op(op_t[k], src_t[k], a_t[k], b_t[k], i_t[k]);
            tick();
            tests++; if (ifs.ex_alu_result !== e_t[k]) begin fails++; $display("FAIL alu_op%0d got %h want %h", k, ifs.ex_alu_result, e_t[k]); end
            tests++; if (ifs.ex_zero !== (e_t[k] == 32'd0)) begin fails++; $display("FAIL alu_zero%0d got %b want %b", k, ifs.ex_zero, (e_t[k] == 32'd0)); end
        end
    endtask

    task automatic test_slt;
        @(negedge clk);
        set_op(2'b10, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h2A);
        tick();
        tests++; if (ifs.ex_alu_result !== 32'd1) begin fails++; $display("FAIL slt_signed_neg got %h want 1", ifs.ex_alu_result); end
        tests++; if (ifu.ex_alu_result !== 32'd0) begin fails++; $display("FAIL slt_unsigned_big got %h want 0", ifu.ex_alu_result); end
        @(negedge clk);
        set_op(2'b10, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h2A);
        tick();
        tests++; if (ifs.ex_alu_result !== 32'd0) begin fails++; $display("FAIL slt_signed_pos got %h want 0", ifs.ex_alu_result); end
        tests++; if (ifu.ex_alu_result !== 32'd1) begin fails++; $display("FAIL slt_unsigned_small got %h want 1", ifu.ex_alu_result); end
    endtask

    task automatic test_regdst_bubble;
        @(negedge clk);
        ifs.regdst = 1'b1; ifs.instr_1511 = 5'd9; ifs.instr_2016 = 5'd4;
        ifs.wb_ctl = 2'b01; ifs.m_ctl = 3'b001;
        set_op(2'b00, 1'b0, 32'd1, 32'd2, 32'd0);
        tick();
        tests++; if (ifs.ex_rd !== 5'd9) begin fails++; $display("FAIL regdst_1511 got %0d want 9", ifs.ex_rd); end
        @(negedge clk);
        ifs.regdst = 1'b0;
        tick();
        tests++; if (ifs.ex_rd !== 5'd4) begin fails++; $display("FAIL regdst_2016 got %0d want 4", ifs.ex_rd); end
        @(negedge clk);
        ifs.id_valid = 1'b0;
        tick();
        tests++; if ({ifs.ex_valid, ifs.ex_wb_ctl, ifs.ex_m_ctl} !== 6'd0) begin
            fails++; $display("FAIL bubble_vld_ctl got %b want 0", {ifs.ex_valid, ifs.ex_wb_ctl, ifs.ex_m_ctl});
        end
        tests++; if (ifs.ex_rd !== 5'd4) begin fails++; $display("FAIL bubble_rd_hold got %0d want 4", ifs.ex_rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp [3];
        exp = '{32'd4, 32'd7, 32'hFF};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            case (k)
                0:       set_op(2'b00, 1'b0, 32'd2, 32'd2, 32'd0);
                1:       set_op(2'b01, 1'b0, 32'd10, 32'd3, 32'd0);
                default: set_op(2'b10, 1'b0, 32'h0F, 32'hF0, 32'h25);
            endcase
            tick();
            tests++; if ({ifs.ex_valid, ifs.ex_alu_result} !== {1'b1, exp[k]}) begin
                fails++; $display("FAIL b2b_%0d got %h want %h", k, {ifs.ex_valid, ifs.ex_alu_result}, {1'b1, exp[k]});
            end
        end
        @(negedge clk);
        ifs.id_valid = 1'b0;
    endtask

`ifdef IEXECUTE_MULT_EN
    task automatic test_mult;
        int n;
        @(negedge clk);
        ifs.wb_ctl = 2'b10; ifs.m_ctl = 3'b000; ifs.regdst = 1'b1; ifs.instr_1511 = 5'd12;
        set_op(2'b10, 1'b0, 32'd3, 32'hFFFF_FFFF, 32'h18);
        #1;
        n = 0;
        while (ifs.ex_busy === 1'b1 && n < 60) begin
            n++;
            if (n == 2) begin
                tests++; if (ifs.ex_valid !== 1'b0) begin fails++; $display("FAIL mul_valid_low got %b want 0", ifs.ex_valid); end
            end
            if (n == 6) ifs.rdata1 = 32'd100;
            @(negedge clk);
            #1;
        end
        tests++; if (n != 33) begin fails++; $display("FAIL mul_busy_cycles got %0d want 33", n); end
        tests++; if ({ifs.ex_valid, ifs.ex_alu_result} !== {1'b1, 32'hFFFF_FFFD}) begin
            fails++; $display("FAIL mul_result got %h want %h", {ifs.ex_valid, ifs.ex_alu_result}, {1'b1, 32'hFFFF_FFFD});
        end
        tests++; if ({ifs.ex_rd, ifs.ex_wb_ctl} !== {5'd12, 2'b10}) begin
            fails++; $display("FAIL mul_bundle got %h want %h", {ifs.ex_rd, ifs.ex_wb_ctl}, {5'd12, 2'b10});
        end
        @(posedge clk);
        #1;
        ifs.id_valid = 1'b0;
        #1;
        tests++; if ({ifs.ex_valid, ifs.ex_busy} !== 2'b00) begin fails++; $display("FAIL mul_valid_once got %b want 00", {ifs.ex_valid, ifs.ex_busy}); end
        tests++; if (ifs.ex_alu_result !== 32'hFFFF_FFFD) begin fails++; $display("FAIL mul_hold got %h want fffffffd", ifs.ex_alu_result); end
    endtask
`else
    task automatic test_mult_disabled;
        @(negedge clk);
        set_op(2'b10, 1'b0, 32'd3, 32'hFFFF_FFFF, 32'h18);
        #1;
        tests++; if (ifs.ex_busy !== 1'b0) begin fails++; $display("FAIL nomul_busy got %b want 0", ifs.ex_busy); end
        tick();
        tests++; if ({ifs.ex_valid, ifs.ex_zero, ifs.ex_alu_result} !== {2'b11, 32'd0}) begin
            fails++; $display("FAIL nomul_result got %h want %h", {ifs.ex_valid, ifs.ex_zero, ifs.ex_alu_result}, {2'b11, 32'd0});
        end
        @(negedge clk);
        ifs.id_valid = 1'b0;
    endtask
`endif

    task automatic test_async_reset;
        @(negedge clk);
        ifs.wb_ctl = 2'b11; ifs.m_ctl = 3'b111; ifs.regdst = 1'b1; ifs.instr_1511 = 5'd17;
`ifdef IEXECUTE_MULT_EN
        set_op(2'b00, 1'b0, 32'd40, 32'd2, 32'd1);
        tick();
        @(negedge clk);
        set_op(2'b10, 1'b0, 32'd5, 32'd7, 32'h18);
        tick();
        repeat (9) tick();
        tests++; if (ifs.ex_busy !== 1'b1) begin fails++; $display("FAIL mid_mul_busy got %b want 1", ifs.ex_busy); end
`else
        set_op(2'b00, 1'b0, 32'd40, 32'd2, 32'd1);
        tick();
        ifs.id_valid = 1'b0;
`endif
        rst = 1'b1;
        #1;
        tests++; if ({ifs.ex_valid, ifs.ex_busy, ifs.ex_zero} !== 3'd0) begin
            fails++; $display("FAIL rst_flags got %b want 000", {ifs.ex_valid, ifs.ex_busy, ifs.ex_zero});
        end
        tests++; if ({ifs.ex_alu_result, ifs.ex_add_result, ifs.ex_rdata2} !== 96'd0) begin
            fails++; $display("FAIL rst_data got %h want 0", {ifs.ex_alu_result, ifs.ex_add_result, ifs.ex_rdata2});
        end
        tests++; if ({ifs.ex_wb_ctl, ifs.ex_m_ctl, ifs.ex_rd} !== 10'd0) begin
            fails++; $display("FAIL rst_ctl got %h want 0", {ifs.ex_wb_ctl, ifs.ex_m_ctl, ifs.ex_rd});
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        set_op(2'b00, 1'b0, 32'd1, 32'd1, 32'd0);
        tick();
        tests++; if ({ifs.ex_valid, ifs.ex_alu_result} !== {1'b1, 32'd2}) begin
            fails++; $display("FAIL post_rst_add got %h want %h", {ifs.ex_valid, ifs.ex_alu_result}, {1'b1, 32'd2});
        end
        tests++; if (ifs.ex_busy !== 1'b0) begin fails++; $display("FAIL post_rst_busy got %b want 0", ifs.ex_busy); end
        @(negedge clk);
        ifs.id_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_branch();
        test_alu_ops();
        test_slt();
        test_regdst_bubble();
        test_back_to_back();
`ifdef IEXECUTE_MULT_EN
        test_mult();
`else
        test_mult_disabled();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
